// File: rtl/bitserial_mac_array.sv
// Bit-serial matrix-multiply engine: MSB-first activation bit-planes are summed
// per channel (stage 1) and shift-accumulated into per-channel results (stage 2).
module bitserial_mac_array #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned NCH    = 4,
    parameter int unsigned W_BITS = 4,
    parameter int unsigned I_BITS = 4,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned OUT_W  = W_BITS + I_BITS + $clog2(LANES) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    input  logic [NCH*LANES*W_BITS-1:0]   in_data_i,
    input  logic                          in_signed_i,
    input  logic                          flush_i,
    output logic                          out_valid_o,
    output logic [NCH*OUT_W-1:0]          out_data_o,
    output logic [$clog2(ROWS)-1:0]       out_row_o,
    output logic                          out_last_o,
    output logic                          busy_o
);

    localparam int unsigned SUM_W = W_BITS + $clog2(LANES);
    localparam int unsigned PL_W  = $clog2(I_BITS);
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic [PL_W-1:0]      plane_q, plane_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;
    logic [PL_W-1:0]      s1_plane_q, s1_plane_d;
    logic                 mode_q, mode_d;
    logic [SUM_W-1:0]     lane_sum_c [NCH];
    logic [SUM_W-1:0]     sum_q [NCH];
    logic [SUM_W-1:0]     sum_d [NCH];
    logic [OUT_W-1:0]     acc_q [NCH];
    logic [OUT_W-1:0]     acc_d [NCH];
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 out_valid_q, out_valid_d;
    logic [NCH*OUT_W-1:0] out_data_q, out_data_d;
    logic [ROW_W-1:0]     out_row_q, out_row_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q;

    // Unsigned adder tree over the lanes of each channel
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            lane_sum_c[c] = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_sum_c[c] = lane_sum_c[c]
                              + SUM_W'(in_data_i[(c*LANES+k)*W_BITS +: W_BITS]);
            end
        end
    end

    // Next-state: flush wins over both the incoming beat and the in-flight stage-1 beat
    always_comb begin
        plane_d     = plane_q;
        s1_valid_d  = 1'b0;
        s1_last_d   = s1_last_q;
        s1_plane_d  = s1_plane_q;
        mode_d      = mode_q;
        sum_d       = sum_q;
        acc_d       = acc_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = 1'b0;

        if (flush_i) begin
            plane_d = '0;
            for (int unsigned c = 0; c < NCH; c++) acc_d[c] = '0;
        end else begin
            if (in_valid_i) begin
                s1_valid_d = 1'b1;
                s1_plane_d = plane_q;
                s1_last_d  = (plane_q == PL_W'(I_BITS-1));
                plane_d    = (plane_q == PL_W'(I_BITS-1)) ? '0 : plane_q + PL_W'(1);
                if (plane_q == '0) mode_d = in_signed_i;
                sum_d = lane_sum_c;
            end
            if (s1_valid_q) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (s1_plane_q == '0)
                        acc_d[c] = mode_q ? OUT_W'(0) - OUT_W'(sum_q[c]) : OUT_W'(sum_q[c]);
                    else
                        acc_d[c] = (acc_q[c] << 1) + OUT_W'(sum_q[c]);
                end
                if (s1_last_q) begin
                    out_valid_d = 1'b1;
                    for (int unsigned c = 0; c < NCH; c++) out_data_d[c*OUT_W +: OUT_W] = acc_d[c];
                    out_row_d  = row_q;
                    out_last_d = (row_q == ROW_W'(ROWS-1));
                    row_d      = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + ROW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plane_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_plane_q  <= '0;
            mode_q      <= 1'b0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                sum_q[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            plane_q     <= plane_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_plane_q  <= s1_plane_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            busy_q      <= (plane_d != '0) || s1_valid_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                sum_q[c] <= sum_d[c];
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Self-checking bench for bitserial_mac_array: table vectors, random tiles with a
// plain-arithmetic matrix model, stalls, flush and mid-row reset.
module tb_bitserial_mac_array;

    localparam int unsigned LANES  = 32;
    localparam int unsigned NCH    = 4;
    localparam int unsigned W_BITS = 4;
    localparam int unsigned I_BITS = 4;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned OUT_W  = W_BITS + I_BITS + $clog2(LANES) + 1;
    localparam int unsigned ROW_W  = $clog2(ROWS);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic [NCH*LANES*W_BITS-1:0] in_data;
    logic                        in_signed;
    logic                        flush;
    logic                        out_valid;
    logic [NCH*OUT_W-1:0]        out_data;
    logic [ROW_W-1:0]            out_row;
    logic                        out_last;
    logic                        busy;

    bitserial_mac_array #(
        .LANES(LANES), .NCH(NCH), .W_BITS(W_BITS), .I_BITS(I_BITS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_signed_i(in_signed), .flush_i(flush), .out_valid_o(out_valid),
        .out_data_o(out_data), .out_row_o(out_row), .out_last_o(out_last), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*OUT_W-1:0] data;
        int                   row;
        bit                   last;
        longint               cyc;
    } exp_t;

    typedef struct {
        int a;
        int w;
        bit sgn;
        int tog;
        int expv;
    } vec_t;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint last_drive_cyc;
    int     act [LANES];
    int     wt  [LANES][NCH];
    int     exp_res [NCH];
    int     exp_row = 0;
    exp_t   q [$];
    exp_t   mon_e;
    vec_t   tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Reference: plain integer matrix product of one activation row with the weight tile
    function automatic void model(input bit sgn);
        for (int c = 0; c < NCH; c++) begin
            int s = 0;
            for (int k = 0; k < LANES; k++) begin
                int a = act[k];
                if (sgn && a >= (1 << (I_BITS-1))) a = a - (1 << I_BITS);
                s += a * wt[k][c];
            end
            exp_res[c] = s;
        end
    endfunction

    task automatic drive_plane(input int p, input bit sin, input bit fl);
        in_valid  = 1'b1;
        flush     = fl;
        in_signed = sin;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < LANES; k++)
                in_data[(c*LANES+k)*W_BITS +: W_BITS] =
                    (((act[k] >> (I_BITS-1-p)) & 1) != 0) ? W_BITS'(wt[k][c]) : '0;
        last_drive_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        in_signed = 1'bx;
        in_data   = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one row; a flush on flush_plane aborts it with no expectation queued
    task automatic send_row(input bit sgn, input int stall_max, input int toggle_plane, input int flush_plane);
        exp_t e;
        for (int p = 0; p < I_BITS; p++) begin
            bit sin = (p != 0 && p == toggle_plane) ? !sgn : sgn;
            if (stall_max > 0) idle(int'($urandom_range(stall_max, 0)));
            if (p == flush_plane) begin
                drive_plane(p, sin, 1'b1);
                return;
            end
            drive_plane(p, sin, 1'b0);
        end
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] v = exp_res[c];
            e.data[c*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        e.row  = exp_row;
        e.last = (exp_row == ROWS-1);
        e.cyc  = last_drive_cyc + 2;
        q.push_back(e);
        exp_row = (exp_row + 1) % ROWS;
    endtask

    task automatic rand_act();
        for (int k = 0; k < LANES; k++) act[k] = int'($urandom_range((1 << I_BITS) - 1, 0));
    endtask

    task automatic rand_wt();
        for (int k = 0; k < LANES; k++)
            for (int c = 0; c < NCH; c++) wt[k][c] = int'($urandom_range((1 << W_BITS) - 1, 0));
    endtask

    // Result monitor: in-order scoreboard with latency check
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", longint'(out_data), longint'(mon_e.data));
                    chk("out_row", longint'(out_row), longint'(mon_e.row));
                    chk("out_last", longint'(out_last), longint'(mon_e.last));
                    chk("latency", cyc, mon_e.cyc);
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("missing_result", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_signed = 1'b0; in_data = '0;
        idle(2);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_row", longint'(out_row), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        idle(2);

        tbl[0] = '{a: 15, w: 15, sgn: 1'b0, tog: -1, expv: 7200};
        tbl[1] = '{a: 15, w: 15, sgn: 1'b1, tog: -1, expv: -480};
        tbl[2] = '{a: 15, w: 15, sgn: 1'b1, tog: 2,  expv: -480};
        tbl[3] = '{a: 0,  w: 15, sgn: 1'b0, tog: -1, expv: 0};
        tbl[4] = '{a: 8,  w: 1,  sgn: 1'b1, tog: 1,  expv: -256};
        tbl[5] = '{a: 7,  w: 15, sgn: 1'b1, tog: -1, expv: 3360};
        tbl[6] = '{a: 8,  w: 15, sgn: 1'b1, tog: 3,  expv: -3840};
        tbl[7] = '{a: 1,  w: 1,  sgn: 1'b0, tog: 2,  expv: 32};
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < LANES; k++) begin
                act[k] = tbl[i].a;
                for (int c = 0; c < NCH; c++) wt[k][c] = tbl[i].w;
            end
            for (int c = 0; c < NCH; c++) exp_res[c] = tbl[i].expv;
            send_row(tbl[i].sgn, 0, tbl[i].tog, -1);
        end
        idle(3);

        // Flush on the final plane, then a fresh row keeps the same row index
        rand_wt();
        rand_act();
        send_row(1'b0, 0, -1, I_BITS-1);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_valid", longint'(out_valid), 0);
            idle(1);
        end
        rand_act();
        model(1'b1);
        send_row(1'b1, 0, -1, -1);
        idle(3);

        for (int t = 0; t < 1000; t++) begin
            rand_wt();
            for (int r = 0; r < ROWS; r++) begin
                bit sgn = 1'($urandom_range(1, 0));
                rand_act();
                model(sgn);
                send_row(sgn, 0, int'($urandom_range(I_BITS, 1)), -1);
            end
        end

        for (int t = 0; t < 200; t++) begin
            rand_wt();
            for (int r = 0; r < ROWS; r++) begin
                bit sgn = 1'($urandom_range(1, 0));
                rand_act();
                model(sgn);
                send_row(sgn, 7, -1, -1);
            end
        end

        // Reset after plane 1 of a row
        rand_act();
        drive_plane(0, 1'b0, 1'b0);
        drive_plane(1, 1'b0, 1'b0);
        chk("busy_mid_row", longint'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", longint'(out_valid), 0);
        chk("async_rst_out_data", longint'(out_data), 0);
        chk("async_rst_out_row", longint'(out_row), 0);
        chk("async_rst_out_last", longint'(out_last), 0);
        chk("async_rst_busy", longint'(busy), 0);
        q.delete();
        exp_row = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        rand_wt();
        rand_act();
        model(1'b0);
        send_row(1'b0, 0, -1, -1);
        idle(5);
        chk("queue_drained", longint'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
